// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity modes, frame-length helper.
// No logic; compile-time only. No flow control.
// Imported by the transmitter, the future receiver and benches.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Total clock cycles occupied by one frame on the line.
    function automatic int frame_cycles(input int clks, input int dbits,
                                        input int par, input int stop);
        return (1 + dbits + par + stop) * clks;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, tick on the last count.
// Latency: tick is combinational from the count register.
// Backpressure: none; clear/enable are obeyed every cycle.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
        $error("uart_baud_tick: CLKS_PER_BIT must be 2..65535");
    end

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !enable || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stop bits.
// Latency: txd drops to the start bit in the cycle after the accepting edge.
// Backpressure: tx_ready only in IDLE or the final stop cycle; source holds tx_valid.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
        DATA_BITS < 5 || DATA_BITS > 9 ||
        (PARITY_EN != 0 && PARITY_EN != 1) ||
        (PARITY_ODD != PAR_EVEN && PARITY_ODD != PAR_ODD) ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
        $error("uart_tx_frame: illegal parameter value");
    end

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic [3:0]           bit_idx, bit_idx_nxt;
    logic                 parity_q, parity_nxt;
    logic                 txd_q, txd_nxt;
    logic                 tick;
    logic                 baud_en;
    logic                 accept;
    logic                 last_stop;
    logic                 frame_end;

    assign baud_en   = (state != IDLE);
    assign last_stop = (bit_idx == 4'(STOP_BITS - 1));
    assign frame_end = (state == STOP) && tick && last_stop;
    assign tx_ready  = (state == IDLE) || frame_end;
    assign accept    = tx_valid && tx_ready;
    assign tx_done   = frame_end;
    assign busy      = (state != IDLE);
    assign txd       = txd_q;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (baud_en),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift_q  <= '1;
            bit_idx  <= '0;
            parity_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state    <= state_nxt;
            shift_q  <= shift_nxt;
            bit_idx  <= bit_idx_nxt;
            parity_q <= parity_nxt;
            txd_q    <= txd_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        bit_idx_nxt = bit_idx;
        parity_nxt  = parity_q;
        txd_nxt     = 1'b1;

        case (state)
            IDLE: begin
                bit_idx_nxt = '0;
            end
            START: begin
                if (tick) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_nxt = {1'b1, shift_q[DATA_BITS-1:1]};
                    if (bit_idx == 4'(DATA_BITS - 1)) begin
                        bit_idx_nxt = '0;
                        state_nxt   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nxt   = STOP;
                    bit_idx_nxt = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (last_stop) begin
                        state_nxt   = IDLE;
                        bit_idx_nxt = '0;
                    end else begin
                        bit_idx_nxt = bit_idx + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                bit_idx_nxt = '0;
            end
        endcase

        // An accept overrides the IDLE fall-through of the final stop bit.
        if (accept) begin
            state_nxt   = START;
            shift_nxt   = tx_data;
            parity_nxt  = (^tx_data) ^ 1'(PARITY_ODD);
            bit_idx_nxt = '0;
        end

        case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = shift_nxt[0];
            PARITY:  txd_nxt = parity_nxt;
            default: txd_nxt = 1'b1;
        endcase
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter that serialises one character per frame: start bit, 5-9 data bits LSB first, optional parity, then 1 or 2 stop bits.
Accepts characters over a valid/ready handshake and supports back-to-back frames with no idle gap.
The baud counter restarts at every frame start, so each bit is exactly CLKS_PER_BIT cycles.
Sits between the host-side byte source (FIFO or register interface) and the serial pad.

Parameters:
CLKS_PER_BIT, 10416, clock cycles per serial bit; legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_EN, 0, 1 = parity bit inserted after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd; ignored when PARITY_EN=0.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
tx_data  input  DATA_BITS  character to send; bit 0 is sent first.
tx_valid  input  1  source has a character on tx_data.
tx_ready  output  1  block can accept a character this cycle.
txd  output  1  serial line; idles high.
busy  output  1  high while any frame bit is on the line.
tx_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset (async assert, sync release): state=IDLE, txd=1, tx_ready=1, busy=0, tx_done=0, baud counter=0, bit index=0, shift register all-ones.
- States: IDLE, START, DATA, PARITY, STOP. txd is registered and driven from the current state: START=0, DATA=shift[0], PARITY=parity bit, STOP=1, IDLE=1.
- Accept rule: transfer occurs on the rising edge where tx_valid=1 and tx_ready=1. tx_data is latched into the shift register on that edge.
- Parity bit: XOR of the latched data bits, XOR PARITY_ODD. It is computed once at latch time.
- tx_ready=1 in IDLE.
- tx_ready=1 in STOP during the final cycle of the last stop bit, the same cycle tx_done=1. This allows a back-to-back accept.
- tx_ready=0 at all other times.
- Latency: on accept in IDLE, the next state is START. txd falls to 0 on the first edge after the accept.
- Bit timing: the baud counter counts 0..CLKS_PER_BIT-1 in every non-IDLE state. At CLKS_PER_BIT-1 the counter wraps to 0 and the bit advances.
- The counter is held at 0 in IDLE and cleared on every accept.
- Transitions (each taken on a counter wrap):
  - START -> DATA.
  - DATA: shift the register right and increment the bit index. After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY -> STOP.
  - STOP: after STOP_BITS bit periods, go to START if an accept occurred on that edge, else IDLE.
- Frame length is (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back frames: on a STOP -> START transition, txd goes high to low with no extra idle cycle.
- busy=1 from the first START cycle through the last STOP cycle. It stays 1 across back-to-back frames.
- tx_valid deasserted without a transfer: no effect. tx_data changes after accept: no effect on the frame in flight.
- Reset mid-frame: the line returns to 1 immediately, the frame is abandoned, and the character is lost. No tx_done is produced.
- Width rules: the baud counter is $clog2(CLKS_PER_BIT) bits wide and the bit index is 4 bits wide. Compare against CLKS_PER_BIT-1 explicitly; the counter never exceeds that value.
- Illegal parameter values are rejected by an elaboration-time check. There is no runtime recovery.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants PAR_EVEN=0 and PAR_ODD=1;
  - a frame-length function frame_cycles(clks, dbits, par, stop), reused by the future receiver and by testbenches.
- One sub-module, uart_baud_tick: a parametrised counter with inputs clk, rst_n, clear, enable and output tick (high when count == CLKS_PER_BIT-1). The future uart_rx_frame reuses it.

Test Plan:
- CLKS_PER_BIT=4, 8N1, send 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. tx_done pulses in cycle 40 after accept; busy is high for exactly 40 cycles.
- CLKS_PER_BIT=4, 8E1, send 0x07 -> parity bit=1; frame of 11 bits, 44 cycles. Same run with PARITY_ODD=1 -> parity bit=0.
- DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=3, send 0x1F -> 0,1,1,1,1,1,1,1, 24 cycles. The upper tx_data bits are ignored.
- tx_valid held high with 0x55 then 0xAA -> the second accept occurs in the tx_done cycle. The next start bit follows with zero gap, and busy never drops between frames.
- Assert rst_n low during data bit 3 of a frame -> txd=1, busy=0, tx_ready=1 asynchronously. No tx_done. After release, a new send of 0x3C completes correctly.
- tx_valid pulsed while busy -> no acceptance (tx_ready=0). The frame in flight is unchanged and the source must hold tx_valid until accept.
